// File: rtl/stream_vector_collector_pkg.sv
// Shared definitions for the scaler output stream: widths, slot select
// and the collector state encoding.
`ifndef STREAM_VECTOR_COLLECTOR_PKG_SV
`define STREAM_VECTOR_COLLECTOR_PKG_SV

`define SVC_SLOT(i, w) ((w)*(i)) +: (w)

package stream_vector_collector_pkg;

  localparam int DATA_WIDTH_DEFAULT = 8;
  localparam int INDEX_PAD = 2;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

endpackage

`endif

// File: rtl/stream_vector_collector.sv
// Collects an in-order index/value beat stream into a vector and
// presents each completed frame on a valid/ready interface.
module stream_vector_collector
  import stream_vector_collector_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEFAULT,
  parameter int INDEX_WIDTH  = DATA_WIDTH + INDEX_PAD,
  parameter int VALUE_AMOUNT = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [INDEX_WIDTH-1:0]             input_index,
  input  logic [DATA_WIDTH-1:0]              input_value,
  input  logic                               input_enable,
  output logic [DATA_WIDTH*VALUE_AMOUNT-1:0] output_vector,
  output logic                               output_valid,
  input  logic                               output_ready,
  output logic                               busy,
  output logic                               error
);

  localparam logic [INDEX_WIDTH-1:0] LAST =
    INDEX_WIDTH'(VALUE_AMOUNT - 1);
  localparam logic [INDEX_WIDTH-1:0] ONE = INDEX_WIDTH'(1);

  state_t                  state, state_next;
  logic [INDEX_WIDTH-1:0]  expected_index, expected_next;
  logic                    error_next;
  logic                    take;
  logic                    wr;
  logic                    hit;
  logic [DATA_WIDTH-1:0]   slot [VALUE_AMOUNT];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= COLLECT;
      expected_index <= '0;
      error          <= 1'b0;
    end else begin
      state          <= state_next;
      expected_index <= expected_next;
      error          <= error_next;
    end
  end

  // Full-width compare: an index past the frame never aliases a slot.
  assign hit = (input_index == expected_index);

  always_comb begin
    state_next    = state;
    expected_next = expected_index;
    error_next    = error;
    take          = 1'b0;
    wr            = 1'b0;
    unique case (state)
      COLLECT: take = input_enable;
      HOLD: begin
        if (output_ready) begin
          state_next = COLLECT;
          take       = input_enable;
        end else if (input_enable) begin
          error_next = 1'b1;
        end
      end
    endcase
    if (take) begin
      if (hit) begin
        wr = 1'b1;
        if (expected_index == LAST) begin
          state_next    = HOLD;
          expected_next = '0;
        end else begin
          expected_next = expected_index + 1'b1;
        end
      end else begin
        // A stray index 0 restarts the frame without losing the beat.
        error_next    = 1'b1;
        wr            = (input_index == '0);
        expected_next = wr ? ONE : '0;
      end
    end
  end

  always_comb begin
    output_valid = (state == HOLD);
    busy         = (state == COLLECT) && (expected_index != '0);
  end

  for (genvar g = 0; g < VALUE_AMOUNT; g++) begin : g_slot
    always_ff @(posedge clk or posedge reset) begin
      if (reset)
        slot[g] <= '0;
      else if (wr && input_index == INDEX_WIDTH'(g))
        slot[g] <= input_value;
    end
    assign output_vector[`SVC_SLOT(g, DATA_WIDTH)] = slot[g];
  end

endmodule

// File: tb/tb_stream_vector_collector.sv
// Scoreboard bench for stream_vector_collector: directed plan plus
// randomized beat streams against a frame-level reference model.
module tb_stream_vector_collector;

  localparam int DW = 8;
  localparam int IW = DW + 2;
  localparam int VA = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [IW-1:0]     input_index;
  logic [DW-1:0]     input_value;
  logic              input_enable;
  logic [DW*VA-1:0]  output_vector;
  logic              output_valid;
  logic              output_ready;
  logic              busy;
  logic              error;

  stream_vector_collector #(
    .DATA_WIDTH(DW), .INDEX_WIDTH(IW), .VALUE_AMOUNT(VA)
  ) dut (
    .clk(clk), .reset(reset),
    .input_index(input_index), .input_value(input_value),
    .input_enable(input_enable),
    .output_vector(output_vector), .output_valid(output_valid),
    .output_ready(output_ready), .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model
  int             m_slot [VA];
  int             m_next;
  bit             m_hold;
  bit             m_err;
  logic [DW*VA-1:0] frame_q [$];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW*VA-1:0] model_vec();
    logic [DW*VA-1:0] v;
    for (int i = 0; i < VA; i++) v[DW*i +: DW] = m_slot[i][DW-1:0];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < VA; i++) m_slot[i] = 0;
    m_next = 0;
    m_hold = 0;
    m_err  = 0;
    frame_q.delete();
  endtask

  task automatic model_beat(input int idx, input int val);
    if (idx == m_next) begin
      m_slot[idx] = val;
      if (idx == VA - 1) begin
        m_hold = 1;
        m_next = 0;
        frame_q.push_back(model_vec());
      end else begin
        m_next = idx + 1;
      end
    end else begin
      m_err = 1;
      if (idx == 0) begin
        m_slot[0] = val;
        m_next = 1;
      end else begin
        m_next = 0;
      end
    end
  endtask

  task automatic model_edge(input bit en, input int idx, input int val,
                            input bit rdy);
    if (m_hold) begin
      if (rdy) begin
        m_hold = 0;
        if (en) model_beat(idx, val);
      end else if (en) begin
        m_err = 1;
      end
    end else if (en) begin
      model_beat(idx, val);
    end
  endtask

  task automatic step(input bit en, input int idx, input int val,
                      input bit rdy);
    input_enable = en;
    input_index  = idx[IW-1:0];
    input_value  = val[DW-1:0];
    output_ready = rdy;
    @(posedge clk);
    model_edge(en, idx, val, rdy);
    #1;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(0, 0, 0, rdy);
  endtask

  task automatic do_reset();
    input_enable = 0;
    output_ready = 0;
    reset = 1;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 0;
  endtask

  // monitor: cycle-level state plus frame scoreboard on each consume
  always @(negedge clk) begin
    chk("valid", output_valid, m_hold);
    chk("busy", busy, !m_hold && m_next != 0);
    chk("error", error, m_err);
    chk("vector", output_vector, model_vec());
    if (!reset && output_valid && output_ready) begin
      if (frame_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL frame_q: consume with no expected frame at %0t",
                 $time);
      end else begin
        chk("frame", output_vector, frame_q.pop_front());
      end
    end
  end

  initial begin
    reset = 1;
    input_enable = 0;
    input_index = '0;
    input_value = '0;
    output_ready = 0;
    model_reset();
    do_reset();
    chk("rst_vec", output_vector, 0);
    chk("rst_valid", output_valid, 0);

    // in-order frame
    step(1, 0, 254, 0);
    step(1, 1, 251, 0);
    step(1, 2, 159, 0);
    step(1, 3, 150, 0);
    chk("frame1_valid", output_valid, 1);
    chk("frame1_vec", output_vector, 32'h969FFBFE);
    chk("frame1_busy", busy, 0);
    chk("frame1_err", error, 0);

    // backpressure then consume
    idle(5, 0);
    chk("bp_vec", output_vector, 32'h969FFBFE);
    chk("bp_valid", output_valid, 1);
    step(0, 0, 0, 1);
    chk("consumed", output_valid, 0);

    // gapped frame
    step(1, 0, 254, 0);
    idle(2, 0);
    chk("gap_busy", busy, 1);
    step(1, 1, 251, 0);
    idle(2, 0);
    step(1, 2, 159, 0);
    idle(2, 0);
    chk("gap_busy2", busy, 1);
    step(1, 3, 150, 0);
    chk("gap_valid", output_valid, 1);
    chk("gap_vec", output_vector, 32'h969FFBFE);
    step(0, 0, 0, 1);

    // out of order
    step(1, 0, 10, 0);
    step(1, 2, 20, 0);
    chk("ooo_err", error, 1);
    chk("ooo_busy", busy, 0);
    step(1, 0, 1, 0);
    step(1, 1, 2, 0);
    step(1, 2, 3, 0);
    step(1, 3, 4, 0);
    chk("ooo_vec", output_vector, 32'h04030201);
    chk("ooo_valid", output_valid, 1);
    chk("ooo_sticky", error, 1);

    // index beyond frame is an error, not slot 0
    do_reset();
    step(1, 4, 55, 0);
    chk("oob_err", error, 1);
    chk("oob_vec", output_vector, 0);

    // overflow in HOLD
    do_reset();
    for (int i = 0; i < VA; i++) step(1, i, i + 1, 0);
    step(1, 0, 99, 0);
    chk("ovf_err", error, 1);
    chk("ovf_vec", output_vector, 32'h04030201);
    chk("ovf_valid", output_valid, 1);

    // simultaneous consume and index-0 beat
    do_reset();
    for (int i = 0; i < VA; i++) step(1, i, i + 1, 0);
    step(1, 0, 77, 1);
    chk("sim_slot0", output_vector[7:0], 77);
    chk("sim_busy", busy, 1);
    chk("sim_valid", output_valid, 0);
    chk("sim_err", error, 0);

    // async reset mid-frame
    do_reset();
    step(1, 0, 5, 0);
    step(1, 1, 6, 0);
    reset = 1;
    model_reset();
    #1;
    chk("async_vec", output_vector, 0);
    chk("async_busy", busy, 0);
    chk("async_err", error, 0);
    #1;
    reset = 0;
    idle(1, 0);
    for (int i = 0; i < VA; i++) step(1, i, 16 * i + 9, 0);
    chk("post_rst_vec", output_vector, 32'h392919_09);
    step(0, 0, 0, 1);

    // randomized streams
    for (int n = 0; n < 3000; n++) begin
      bit en;
      bit rdy;
      int idx;
      en  = ($urandom_range(0, 99) < 60);
      rdy = ($urandom_range(0, 99) < 40);
      if ($urandom_range(0, 99) < 90)
        idx = m_hold ? 0 : m_next;
      else
        idx = $urandom_range(0, VA + 1);
      step(en, idx, $urandom_range(0, 255), rdy);
      if ($urandom_range(0, 999) == 0) do_reset();
    end
    idle(3, 1);
    chk("queue_drained", frame_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
